voice_scheduler: RTL
====================

Name: voice_scheduler

Overview:
- Allocates note-on/note-off events onto NUM_VOICES voice slots that feed the 8-input sample mixer.
- Sequences the mixer once per audio sample tick: pulses generate_new_sample, waits for new_sample_ready, then latches the mixed sample and presents it downstream.
- Sits between the MIDI/score event decoder and the per-voice wave generators, mixer and codec interface.

Parameters:
- NUM_VOICES, 8, number of voice slots; must match mixer inputs.
- NOTE_W, 7, note index width.
- AGE_W, 8, per-voice age counter width (saturating).
- TIMEOUT, 64, max cycles to wait for new_sample_ready.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ev_valid  in  1  event present
- ev_ready  out  1  event accepted when ev_valid and ev_ready are both high
- ev_is_on  in  1  1 = note-on, 0 = note-off
- ev_note  in  NOTE_W  note index
- voice_active  out  NUM_VOICES  per-voice gate
- voice_note  out  NUM_VOICES*NOTE_W  note per voice; voice i occupies [i*NOTE_W +: NOTE_W]
- voice_retrig  out  NUM_VOICES  1-cycle pulse when a voice is (re)started
- drop  out  1  1-cycle pulse when a note-on is discarded
- sample_tick  in  1  1-cycle audio-rate strobe
- generate_new_sample  out  1  1-cycle request to mixer
- new_sample_ready  in  1  mixer result valid
- mix_sample  in  16  mixer output (signed)
- sample_out  out  16  latched sample
- sample_valid  out  1  1-cycle pulse when sample_out updates
- overrun  out  1  sticky error flag

Behaviour:
- Reset values: ev_ready=0, voice_active=0, voice_note=0, voice_retrig=0, drop=0, generate_new_sample=0, sample_out=0, sample_valid=0, overrun=0, all ages=0. Both FSMs return to IDLE. Reset mid-operation abandons any event or sample in flight.
- Allocation FSM: IDLE -> SEARCH -> COMMIT -> IDLE.
  - ev_ready=1 only in IDLE; acceptance moves the FSM to SEARCH and registers ev_is_on and ev_note.
  - SEARCH registers match / free / oldest indices from the voice table.
  - COMMIT writes the table. Outputs change on the clock edge ending COMMIT, i.e. 3 cycles after acceptance.
  - Throughput: 1 event per 3 cycles.
- Note-on priority:
  - (1) An active voice already holding ev_note is retriggered.
  - (2) Otherwise the lowest-index inactive voice is used.
  - (3) Otherwise the oldest active voice is stolen: largest age, ties to the lowest index.
  - The chosen voice gets active=1, note=ev_note, age=0, and voice_retrig[i] pulses.
- Note-off: every active voice holding ev_note is cleared to active=0; note is held. A note-off matching no voice is ignored with no pulse.
- Ages: on each generate_new_sample pulse, every active voice's age increments, saturating at 2^AGE_W-1. Inactive voice ages freeze.
- Sample FSM: IDLE -> WAIT -> IDLE.
  - On sample_tick in IDLE: generate_new_sample=1 for exactly 1 cycle, then go to WAIT.
  - In WAIT, on new_sample_ready: sample_out<=mix_sample, sample_valid pulses the next cycle, return to IDLE.
  - If the TIMEOUT count expires in WAIT: set overrun, return to IDLE, sample_out holds its old value, no sample_valid.
  - sample_tick arriving in WAIT: set overrun; the tick is dropped.
  - new_sample_ready seen in IDLE: ignored.
- overrun is cleared only by reset.
- The two FSMs are independent. An age increment and a COMMIT reset of the same voice in the same cycle resolve to age=0.

Optional Feature:
- Macro VOICE_STEAL_EN.
- Defined: full-table note-on steals the oldest voice (rule 3).
- Undefined: full-table note-on is discarded, drop pulses for 1 cycle in COMMIT, and the table is unchanged. The age logic is still built, for retrigger bookkeeping.

Test Plan:
- Reset, then note-on 60 → voice 0 active, note 60, voice_retrig=0x01, 3 cycles after acceptance; ev_ready low for the 2 intervening cycles.
- Note-ons 60..67 then note-on 70 with 5 ticks between each → (VOICE_STEAL_EN) voice 0 stolen, note 70, retrig=0x01; (undefined) drop pulse, table unchanged.
- Voices hold 60 and 62; note-on 62 → voice 1 retriggered, age 0, no new voice. Note-off 62 → voice_active[1]=0. Note-off 99 → no change.
- sample_tick; mixer returns 0x1234 three cycles later → generate_new_sample 1-cycle pulse, sample_out=0x1234, a single sample_valid pulse.
- sample_tick with new_sample_ready never asserted → overrun=1 after 64 cycles; a second tick is then serviced normally.
- Assert reset_n low during WAIT and during SEARCH → all outputs return to reset values immediately; a fresh event after release allocates voice 0.

Source files
------------

// File: rtl/voice_scheduler_if.sv
// voice_scheduler_if: note event handshake between the event decoder and the voice scheduler
// Signals: ev_valid/ev_ready handshake, ev_is_on (1 = note-on), ev_note (note index).
// Modports: master = event source, slave = voice scheduler.
interface voice_scheduler_if #(
    parameter int NOTE_W = 7
);
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_is_on;
    logic [NOTE_W-1:0] ev_note;
    modport master (output ev_valid, ev_is_on, ev_note, input ev_ready);
    modport slave (input ev_valid, ev_is_on, ev_note, output ev_ready);
endinterface

// File: rtl/voice_scheduler.sv
// voice_scheduler: allocates note events onto voice slots and sequences the mixer once per sample tick
// Ports: clk, reset_n (async active-low); ev (event handshake, slave modport);
//   voice_active/voice_note/voice_retrig/drop: voice table and its 1-cycle pulses;
//   sample_tick, generate_new_sample, new_sample_ready, mix_sample: mixer sequencing;
//   sample_out/sample_valid: latched mixed sample; overrun: sticky timing error.
// Macro VOICE_STEAL_EN: defined = note-on into a full table steals the oldest voice,
//   undefined = that note-on is dropped and the table is left unchanged.
module voice_scheduler #(
    parameter int NUM_VOICES = 8,
    parameter int NOTE_W     = 7,
    parameter int AGE_W      = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    voice_scheduler_if.slave             ev,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_retrig,
    output logic                         drop,
    input  logic                         sample_tick,
    output logic                         generate_new_sample,
    input  logic                         new_sample_ready,
    input  logic [15:0]                  mix_sample,
    output logic [15:0]                  sample_out,
    output logic                         sample_valid,
    output logic                         overrun
);
    localparam int IW = $clog2(NUM_VOICES);
    localparam int CW = $clog2(TIMEOUT);
`ifdef VOICE_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif
    typedef enum logic [1:0] {A_IDLE, A_SEARCH, A_COMMIT} a_state_t;
    typedef enum logic {S_IDLE, S_WAIT} s_state_t;
    a_state_t              a_state_q, a_state_d;
    s_state_t              s_state_q, s_state_d;
    logic                  ev_ready_q, ev_ready_d, on_q, on_d;
    logic [NOTE_W-1:0]     ev_note_q, ev_note_d;
    logic                  match_hit_q, match_hit_d, free_hit_q, free_hit_d;
    logic [IW-1:0]         match_idx_q, match_idx_d, free_idx_q, free_idx_d, old_idx_q, old_idx_d;
    logic [NUM_VOICES-1:0] active_q, active_d, retrig_q, retrig_d;
    logic [NOTE_W-1:0]     note_q [NUM_VOICES];
    logic [NOTE_W-1:0]     note_d [NUM_VOICES];
    logic [AGE_W-1:0]      age_q [NUM_VOICES];
    logic [AGE_W-1:0]      age_d [NUM_VOICES];
    logic                  drop_q, drop_d, gen_q, gen_d, valid_q, valid_d, overrun_q, overrun_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [15:0]           sample_q, sample_d;
    logic [NUM_VOICES-1:0] hit_mask, age_clr;
    logic                  f_hit;
    logic [IW-1:0]         m_idx, f_idx, o_idx, pick;
    logic [AGE_W-1:0]      old_age;
    logic                  take;

    // Table lookup against the registered event note; descending scan so the lowest index wins.
    always_comb begin
        hit_mask = '0;
        m_idx = '0;
        f_hit = 1'b0;
        f_idx = '0;
        o_idx = '0;
        old_age = age_q[0];
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            hit_mask[i] = active_q[i] && note_q[i] == ev_note_q;
            if (hit_mask[i]) m_idx = IW'(i);
            if (!active_q[i]) begin
                f_hit = 1'b1;
                f_idx = IW'(i);
            end
        end
        // Strict compare keeps the lowest index on equal ages.
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (age_q[i] > old_age) begin
                old_age = age_q[i];
                o_idx = IW'(i);
            end
        end
    end

    always_comb begin
        a_state_d = a_state_q;
        ev_ready_d = ev_ready_q;
        on_d = on_q;
        ev_note_d = ev_note_q;
        match_hit_d = match_hit_q;
        match_idx_d = match_idx_q;
        free_hit_d = free_hit_q;
        free_idx_d = free_idx_q;
        old_idx_d = old_idx_q;
        active_d = active_q;
        note_d = note_q;
        retrig_d = '0;
        drop_d = 1'b0;
        age_clr = '0;
        take = match_hit_q | free_hit_q | STEAL;
        pick = match_hit_q ? match_idx_q : free_hit_q ? free_idx_q : old_idx_q;
        case (a_state_q)
            A_IDLE: begin
                ev_ready_d = !(ev.ev_valid && ev_ready_q);
                if (ev.ev_valid && ev_ready_q) begin
                    a_state_d = A_SEARCH;
                    on_d = ev.ev_is_on;
                    ev_note_d = ev.ev_note;
                end
            end
            A_SEARCH: begin
                a_state_d = A_COMMIT;
                match_hit_d = |hit_mask;
                match_idx_d = m_idx;
                free_hit_d = f_hit;
                free_idx_d = f_idx;
                old_idx_d = o_idx;
            end
            default: begin
                a_state_d = A_IDLE;
                ev_ready_d = 1'b1;
                drop_d = on_q && !take;
                if (on_q && take) begin
                    active_d[pick] = 1'b1;
                    note_d[pick] = ev_note_q;
                    age_clr[pick] = 1'b1;
                    retrig_d[pick] = 1'b1;
                end
                if (!on_q) active_d = active_q & ~hit_mask;
            end
        endcase
        // A commit restart of a voice overrides a same-cycle age increment.
        for (int i = 0; i < NUM_VOICES; i++)
            age_d[i] = age_clr[i] ? '0 : (gen_q && active_q[i] && age_q[i] != '1) ? age_q[i] + 1'b1 : age_q[i];
        s_state_d = s_state_q;
        cnt_d = cnt_q;
        gen_d = 1'b0;
        valid_d = 1'b0;
        sample_d = sample_q;
        overrun_d = overrun_q;
        if (s_state_q == S_IDLE) begin
            if (sample_tick) begin
                s_state_d = S_WAIT;
                gen_d = 1'b1;
                cnt_d = '0;
            end
        end else begin
            if (sample_tick) overrun_d = 1'b1;
            if (new_sample_ready) begin
                s_state_d = S_IDLE;
                sample_d = mix_sample;
                valid_d = 1'b1;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                s_state_d = S_IDLE;
                overrun_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_state_q <= A_IDLE;
            s_state_q <= S_IDLE;
            ev_ready_q <= 1'b0;
            on_q <= 1'b0;
            ev_note_q <= '0;
            match_hit_q <= 1'b0;
            match_idx_q <= '0;
            free_hit_q <= 1'b0;
            free_idx_q <= '0;
            old_idx_q <= '0;
            active_q <= '0;
            retrig_q <= '0;
            note_q <= '{default: '0};
            age_q <= '{default: '0};
            drop_q <= 1'b0;
            gen_q <= 1'b0;
            valid_q <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q <= '0;
            sample_q <= '0;
        end else begin
            a_state_q <= a_state_d;
            s_state_q <= s_state_d;
            ev_ready_q <= ev_ready_d;
            on_q <= on_d;
            ev_note_q <= ev_note_d;
            match_hit_q <= match_hit_d;
            match_idx_q <= match_idx_d;
            free_hit_q <= free_hit_d;
            free_idx_q <= free_idx_d;
            old_idx_q <= old_idx_d;
            active_q <= active_d;
            retrig_q <= retrig_d;
            note_q <= note_d;
            age_q <= age_d;
            drop_q <= drop_d;
            gen_q <= gen_d;
            valid_q <= valid_d;
            overrun_q <= overrun_d;
            cnt_q <= cnt_d;
            sample_q <= sample_d;
        end
    end

    assign ev.ev_ready = ev_ready_q;
    assign voice_active = active_q;
    assign voice_retrig = retrig_q;
    assign drop = drop_q;
    assign generate_new_sample = gen_q;
    assign sample_out = sample_q;
    assign sample_valid = valid_q;
    assign overrun = overrun_q;
    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_note
        assign voice_note[v*NOTE_W +: NOTE_W] = note_q[v];
    end
endmodule
